serial_borrow_subtractor_16_bit: RTL

Multi-cycle 16-bit subtractor: computes diff = a − b − bin one 4-bit digit per clock, rippling the borrow between digits through a register. It is the subtract-direction companion to the team's 4-bit-sliced ripple-carry adder. It trades latency for a single 4-bit datapath slice, and uses valid/ready handshakes on both input and result.

---
 rtl/adders_pkg.sv | 18 +
 rtl/borrow_subtract_4_bit.sv | 22 ++
 rtl/serial_borrow_subtractor_16_bit.sv | 115 +++++++++++
 3 files changed

// File: rtl/adders_pkg.sv
// Shared types and constants for the digit-serial adder/subtractor family.
// Combinational helpers only; no state, no handshake.
package adders_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_DIGIT_W = 4;

  function automatic int num_digits(input int width, input int digit_w);
    return width / digit_w;
  endfunction

endpackage

// File: rtl/borrow_subtract_4_bit.sv
// One DIGIT_W-bit slice of a - b - bin with borrow out; purely combinational,
// zero latency, no backpressure.
module borrow_subtract_4_bit
  import adders_pkg::*;
#(
  parameter int DIGIT_W = DEF_DIGIT_W
) (
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               bin,
  output logic [DIGIT_W-1:0] d,
  output logic               bout
);

  // One extra bit catches the wrap below zero, which is exactly the borrow.
  logic [DIGIT_W:0] r;

  assign r    = {1'b0, a} - {1'b0, b} - {{DIGIT_W{1'b0}}, bin};
  assign d    = r[DIGIT_W-1:0];
  assign bout = r[DIGIT_W];

endmodule

// File: rtl/serial_borrow_subtractor_16_bit.sv
// Digit-serial diff = a - b - bin, one DIGIT_W slice per cycle; N cycles accept->out_valid,
// single operation in flight, result held until out_ready. SUB_OVF_EN adds the ovf output.
module serial_borrow_subtractor_16_bit
  import adders_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DIGIT_W = DEF_DIGIT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = num_digits(WIDTH, DIGIT_W);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [CW-1:0]      cnt;
  logic               brw;
  logic [DIGIT_W-1:0] a_dig, b_dig, d_dig;
  logic               brw_nxt;
  logic               accept, step, last;

  assign a_dig = a_q[cnt*DIGIT_W +: DIGIT_W];
  assign b_dig = b_q[cnt*DIGIT_W +: DIGIT_W];

  borrow_subtract_4_bit #(.DIGIT_W(DIGIT_W)) u_digit (
    .a    (a_dig),
    .b    (b_dig),
    .bin  (brw),
    .d    (d_dig),
    .bout (brw_nxt)
  );

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs come straight from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      cnt   <= '0;
      brw   <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
`ifdef SUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q <= a;
        b_q <= b;
        brw <= bin;
        cnt <= '0;
      end
      if (step) begin
        diff[cnt*DIGIT_W +: DIGIT_W] <= d_dig;
        brw <= brw_nxt;
        // Counter parks on the last digit so it never leaves 0..N-1.
        if (!last) cnt <= cnt + CW'(1);
      end
      if (last) begin
        bout <= brw_nxt;
`ifdef SUB_OVF_EN
        // The top digit's MSB is the result sign, produced on this same edge.
        ovf  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_dig[DIGIT_W-1] != a_q[WIDTH-1]);
`endif
      end
    end
  end

endmodule
